// File: rtl/clint_ctrl.sv
// Core-local trap controller: decodes ecall/ebreak/mret/external interrupt in execute,
// writes mepc/mstatus/mcause one per cycle while holding the pipeline, then redirects the PC.
module clint_ctrl #(
    parameter logic [31:0] CAUSE_ECALL   = 32'd11,
    parameter logic [31:0] CAUSE_EBREAK  = 32'd3,
    parameter logic [31:0] CAUSE_EXT_INT = 32'h8000_000B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        int_flag_i,
    input  logic        global_int_en_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        csr_wen_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MSTATUS,
        S_MCAUSE,
        S_MRET,
        S_JUMP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] epc_q, epc_d;
    logic        mret_q, mret_d;

    logic is_ecall, is_ebreak, is_mret, is_int;

    // Trap entry: MPIE takes the old MIE, MIE is cleared; every other bit passes through.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r    = ms;
        r[7] = ms[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // Trap return: MIE takes MPIE, MPIE is set.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r    = ms;
        r[3] = ms[7];
        r[7] = 1'b1;
        return r;
    endfunction

    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_mret   = (inst_i == INST_MRET);
    assign is_int    = int_flag_i & global_int_en_i;

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        mstatus_d    = mstatus_q;
        epc_d        = epc_q;
        mret_d       = mret_q;
        csr_wen_o    = 1'b0;
        csr_waddr_o  = 12'h000;
        csr_wdata_o  = 32'h0;
        hold_flag_o  = 1'b0;
        int_assert_o = 1'b0;
        int_addr_o   = 32'h0;

        case (state_q)
            S_IDLE: begin
                // Synchronous events outrank the interrupt in the same cycle.
                if (is_ecall || is_ebreak) begin
                    hold_flag_o = 1'b1;
                    cause_d     = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                    epc_d       = inst_addr_i;
                    mstatus_d   = csr_mstatus_i;
                    mret_d      = 1'b0;
                    state_d     = S_MEPC;
                end else if (is_mret) begin
                    hold_flag_o = 1'b1;
                    mstatus_d   = csr_mstatus_i;
                    mret_d      = 1'b1;
                    state_d     = S_MRET;
                end else if (is_int) begin
                    hold_flag_o = 1'b1;
                    cause_d     = CAUSE_EXT_INT;
                    epc_d       = jump_flag_i ? jump_addr_i : inst_addr_i;
                    mstatus_d   = csr_mstatus_i;
                    mret_d      = 1'b0;
                    state_d     = S_MEPC;
                end
            end
            S_MEPC: begin
                hold_flag_o = 1'b1;
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = epc_q;
                state_d     = S_MSTATUS;
            end
            S_MSTATUS: begin
                hold_flag_o = 1'b1;
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = trap_mstatus(mstatus_q);
                state_d     = S_MCAUSE;
            end
            S_MCAUSE: begin
                hold_flag_o = 1'b1;
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_q;
                state_d     = S_JUMP;
            end
            S_MRET: begin
                hold_flag_o = 1'b1;
                csr_wen_o   = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mret_mstatus(mstatus_q);
                state_d     = S_JUMP;
            end
            S_JUMP: begin
                hold_flag_o  = 1'b1;
                int_assert_o = 1'b1;
                int_addr_o   = mret_q ? csr_mepc_i : csr_mtvec_i;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cause_q   <= 32'h0;
            mstatus_q <= 32'h0;
            epc_q     <= 32'h0;
            mret_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            mstatus_q <= mstatus_d;
            epc_q     <= epc_d;
            mret_q    <= mret_d;
        end
    end

endmodule
